transducer_fire_sequencer: RTL and testbench
============================================

# transducer_fire_sequencer

Upstream controller for a bank of per-channel transducer output stages. It holds the per-channel phase delays, the shared charge time and the channel mask, and drives the bank's handshake: channel reset, then mark, then go. It also collects per-channel completion and warning flags, repeats a programmed number of shots at a programmed interval, and aborts on channel warning, timeout or external abort.

## Interface
- NCH, 8: number of channels, 1..16.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cfgWe  in  1  config write strobe; ignored while busy.
- cfgAddr  in  5  0x00-0x0F phaseDelay[ch] (ignored if ch >= NCH); 0x10 chargeTime (low 9 bits); 0x11 mask (low NCH bits); 0x12 pulseCount; 0x13 interval; 0x14 timeout.
- cfgData  in  16  write data.
- trigger  in  1  start request, sampled in IDLE only.
- abort  in  1  stop request; acted on in any non-IDLE state.
- chanFireComplete  in  NCH  fireComplete from each channel.
- chanWarning  in  NCH  warning from each channel.
- chanRst  out  1  reset to channel bank.
- onYourMark  out  1  mark strobe to channel bank.
- gogogo  out  1  go strobe to channel bank.
- chargeTime  out  9  registered charge time.
- phaseDelay  out  NCH*16  per-channel delay; channel i at bits [16i+15:16i].
- mask  out  NCH  per-channel fire inhibit.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse after the last shot completes normally.
- fault  out  1  sticky error flag.
- faultCode  out  2  1 = channel warning, 2 = timeout, 3 = abort.
- shotCount  out  16  shots completed in the current run.

## Operation
- States: IDLE, CRST, MARK, FIRE, WAIT, GAP, FAULT.
- IDLE: config writes take effect on the next cycle.
  - trigger with pulseCount != 0 → CRST. Clears fault, faultCode and shotCount.
  - trigger with pulseCount == 0 → ignored.
- CRST (1 cycle): chanRst=1. Returns all channels to their idle state → MARK.
- MARK (2 cycles): onYourMark=1, gogogo=0. Channels latch phaseDelay and chargeTime, and their fireComplete deasserts → FIRE.
- FIRE (1 cycle): onYourMark=1, gogogo=1. The timeout counter loads `timeout` → WAIT.
- WAIT: all outputs to the bank low.
  - Exit when &chanFireComplete: shotCount += 1.
    - If shotCount (post-increment) == pulseCount → IDLE with done=1.
    - Else → GAP, with the interval counter loaded.
  - The timeout counter decrements each cycle. Reaching 0 before completion → FAULT, code 2.
  - timeout == 0 disables the timeout.
- GAP: counts `interval` cycles then → CRST. interval == 0 means GAP lasts 1 cycle.
- Fault sources, in any of CRST..GAP:
  - Any chanWarning bit high → FAULT, code 1. This takes priority over completion in the same cycle.
  - abort → FAULT, code 3. This takes priority over warning.
- FAULT (1 cycle): chanRst=1, fault=1, faultCode latched → IDLE with no done pulse.
- Masked channels still complete their handshake and are included in the fireComplete AND.
- shotCount saturates at 0xFFFF.

## Timing
- All outputs registered.
- Trigger sampled at edge k:
  - chanRst high in cycle k+1.
  - onYourMark high in cycles k+2..k+4.
  - gogogo high in cycle k+4 only.
- WAIT completion seen at edge m: done or GAP entry visible in cycle m+1.
- Reset values:
  - state IDLE; chanRst=1 during reset and 0 after.
  - onYourMark=0, gogogo=0, busy=0, done=0, fault=0, faultCode=0, shotCount=0.
  - All config registers 0, so mask=0, chargeTime=0 and phaseDelay=0.
- rst mid-run: IDLE on the next cycle with no done. Config is cleared.
- A cfgWe coinciding with an accepted trigger is applied; it is the last accepted write.

## Test plan
- NCH=4, pd={0,3,5,7}, chargeTime=10, pulseCount=1, model channels: trigger → chanRst cycle 1, mark cycles 2-4, go cycle 4, done one cycle after the last channel completes, shotCount=1.
- pulseCount=3, interval=20: exactly three CRST/MARK/FIRE sequences, 20+1 GAP cycles between completions, one done pulse, shotCount=3.
- Channel 2 warning asserted in WAIT: FAULT next cycle, chanRst pulse, fault=1, faultCode=1, no done.
- timeout=50, channel 1 fireComplete held low: FAULT exactly 50 cycles after WAIT entry, faultCode=2.
- abort and warning in the same GAP cycle → faultCode=3. trigger with pulseCount=0 → busy stays 0.
- cfgWe during busy leaves outputs unchanged. rst during WAIT → all outputs at reset values, no done.

Source files
------------

// File: rtl/transducer_fire_sequencer.sv
// Upstream sequencer for a bank of transducer output stages: holds the
// per-channel phase delays, shared charge time and mask, drives the
// reset/mark/go handshake, repeats shots at a programmed interval and
// aborts on channel warning, timeout or external abort.
//
// state | meaning
// IDLE  | waiting for trigger, config writable
// CRST  | one-cycle channel reset
// MARK  | two cycles of onYourMark, channels latch delay/charge
// FIRE  | one cycle of onYourMark+gogogo, timeout counter loaded
// WAIT  | waiting for all channels to report fireComplete
// GAP   | inter-shot interval (interval+1 cycles)
// FAULT | one-cycle channel reset after an error, then IDLE
module transducer_fire_sequencer #(
   parameter int NCH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfgWe,
   input  logic [4:0]        cfgAddr,
   input  logic [15:0]       cfgData,
   input  logic              trigger,
   input  logic              abort,
   input  logic [NCH-1:0]    chanFireComplete,
   input  logic [NCH-1:0]    chanWarning,
   output logic              chanRst,
   output logic              onYourMark,
   output logic              gogogo,
   output logic [8:0]        chargeTime,
   output logic [NCH*16-1:0] phaseDelay,
   output logic [NCH-1:0]    mask,
   output logic              busy,
   output logic              done,
   output logic              fault,
   output logic [1:0]        faultCode,
   output logic [15:0]       shotCount
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CRST  = 3'd1;
   localparam logic [2:0] S_MARK  = 3'd2;
   localparam logic [2:0] S_FIRE  = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;
   localparam logic [2:0] S_GAP   = 3'd5;
   localparam logic [2:0] S_FAULT = 3'd6;

   localparam logic [1:0] FC_WARN    = 2'd1;
   localparam logic [1:0] FC_TIMEOUT = 2'd2;
   localparam logic [1:0] FC_ABORT   = 2'd3;

   logic [2:0]         state_q, state_d;
   logic [15:0]        cnt_q, cnt_d;
   logic [15:0]        shot_count_q, shot_count_d;
   logic               fault_q, fault_d;
   logic [1:0]         fault_code_q, fault_code_d;
   logic               done_q, done_d;
   logic               chan_rst_q, chan_rst_d;
   logic               mark_q, mark_d;
   logic               go_q, go_d;
   logic               busy_q, busy_d;

   logic [15:0]        pulse_count_q, pulse_count_d;
   logic [15:0]        interval_q, interval_d;
   logic [15:0]        timeout_q, timeout_d;
   logic [8:0]         charge_time_q, charge_time_d;
   logic [NCH-1:0]     mask_q, mask_d;
   logic [NCH*16-1:0]  phase_delay_q, phase_delay_d;

   logic               all_done;
   logic               any_warn;
   logic               run_state;
   logic [15:0]        shot_inc;

   assign all_done  = &chanFireComplete;
   assign any_warn  = |chanWarning;
   assign run_state = (state_q != S_IDLE) && (state_q != S_FAULT);
   assign shot_inc  = (shot_count_q == 16'hFFFF) ? shot_count_q : 16'(shot_count_q + 16'd1);

   // Config register file; writes only land while idle.
   always_comb begin
      pulse_count_d = pulse_count_q;
      interval_d    = interval_q;
      timeout_d     = timeout_q;
      charge_time_d = charge_time_q;
      mask_d        = mask_q;
      phase_delay_d = phase_delay_q;
      if (cfgWe && (state_q == S_IDLE)) begin
         if (!cfgAddr[4]) begin
            for (int i = 0; i < NCH; i++) begin
               if (cfgAddr[3:0] == 4'(i)) phase_delay_d[i*16 +: 16] = cfgData;
            end
         end else begin
            case (cfgAddr)
               5'h10:   charge_time_d = cfgData[8:0];
               5'h11:   mask_d        = cfgData[NCH-1:0];
               5'h12:   pulse_count_d = cfgData;
               5'h13:   interval_d    = cfgData;
               5'h14:   timeout_d     = cfgData;
               default: ;
            endcase
         end
      end
   end

   // Sequencer next state; cnt is shared by MARK length, timeout and gap.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      shot_count_d = shot_count_q;
      fault_d      = fault_q;
      fault_code_d = fault_code_q;
      done_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (trigger && (pulse_count_q != 16'd0)) begin
               state_d      = S_CRST;
               fault_d      = 1'b0;
               fault_code_d = 2'd0;
               shot_count_d = 16'd0;
            end
         end
         S_CRST: begin
            state_d = S_MARK;
            cnt_d   = 16'd1;
         end
         S_MARK: begin
            if (cnt_q == 16'd0) state_d = S_FIRE;
            else                cnt_d   = 16'(cnt_q - 16'd1);
         end
         S_FIRE: begin
            state_d = S_WAIT;
            cnt_d   = timeout_q;
         end
         S_WAIT: begin
            if (all_done) begin
               shot_count_d = shot_inc;
               if (shot_inc == pulse_count_q) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_GAP;
                  cnt_d   = interval_q;
               end
            end else if ((timeout_q != 16'd0) && (cnt_q == 16'd1)) begin
               state_d      = S_FAULT;
               fault_code_d = FC_TIMEOUT;
            end else if (cnt_q != 16'd0) begin
               cnt_d = 16'(cnt_q - 16'd1);
            end
         end
         S_GAP: begin
            if (cnt_q == 16'd0) state_d = S_CRST;
            else                cnt_d   = 16'(cnt_q - 16'd1);
         end
         S_FAULT: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Abort beats warning, and both beat completion or timeout.
      if (run_state && (abort || any_warn)) begin
         state_d      = S_FAULT;
         shot_count_d = shot_count_q;
         done_d       = 1'b0;
         fault_code_d = abort ? FC_ABORT : FC_WARN;
      end
      if (state_d == S_FAULT) fault_d = 1'b1;
   end

   // Bank handshake outputs are decoded from the next state so they are registered.
   always_comb begin
      chan_rst_d = (state_d == S_CRST) || (state_d == S_FAULT);
      mark_d     = (state_d == S_MARK) || (state_d == S_FIRE);
      go_d       = (state_d == S_FIRE);
      busy_d     = (state_d != S_IDLE);
   end

   // State, counters, outputs and config registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         shot_count_q  <= '0;
         fault_q       <= 1'b0;
         fault_code_q  <= '0;
         done_q        <= 1'b0;
         chan_rst_q    <= 1'b1;
         mark_q        <= 1'b0;
         go_q          <= 1'b0;
         busy_q        <= 1'b0;
         pulse_count_q <= '0;
         interval_q    <= '0;
         timeout_q     <= '0;
         charge_time_q <= '0;
         mask_q        <= '0;
         phase_delay_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         shot_count_q  <= shot_count_d;
         fault_q       <= fault_d;
         fault_code_q  <= fault_code_d;
         done_q        <= done_d;
         chan_rst_q    <= chan_rst_d;
         mark_q        <= mark_d;
         go_q          <= go_d;
         busy_q        <= busy_d;
         pulse_count_q <= pulse_count_d;
         interval_q    <= interval_d;
         timeout_q     <= timeout_d;
         charge_time_q <= charge_time_d;
         mask_q        <= mask_d;
         phase_delay_q <= phase_delay_d;
      end
   end

   assign chanRst    = chan_rst_q;
   assign onYourMark = mark_q;
   assign gogogo     = go_q;
   assign chargeTime = charge_time_q;
   assign phaseDelay = phase_delay_q;
   assign mask       = mask_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign fault      = fault_q;
   assign faultCode  = fault_code_q;
   assign shotCount  = shot_count_q;

endmodule

// File: tb/tb_transducer_fire_sequencer.sv
// Directed bench for transducer_fire_sequencer with NCH=4 and a simple
// channel model that completes phaseDelay+chargeTime cycles after go.
module tb_transducer_fire_sequencer;

   localparam int NCH = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              cfgWe;
   logic [4:0]        cfgAddr;
   logic [15:0]       cfgData;
   logic              trigger;
   logic              abort;
   logic [NCH-1:0]    chanFireComplete = '0;
   logic [NCH-1:0]    chanWarning;
   logic              chanRst;
   logic              onYourMark;
   logic              gogogo;
   logic [8:0]        chargeTime;
   logic [NCH*16-1:0] phaseDelay;
   logic [NCH-1:0]    mask;
   logic              busy;
   logic              done;
   logic              fault;
   logic [1:0]        faultCode;
   logic [15:0]       shotCount;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   int             pd_m [NCH] = '{0, 3, 5, 7};
   int             ct_m       = 10;
   int             ch_cnt [NCH];
   logic [NCH-1:0] ch_armed  = '0;
   logic [NCH-1:0] ch_comp   = '0;
   logic [NCH-1:0] hold_low  = '0;

   transducer_fire_sequencer #(.NCH(NCH)) dut (
      .clk(clk), .rst(rst), .cfgWe(cfgWe), .cfgAddr(cfgAddr), .cfgData(cfgData),
      .trigger(trigger), .abort(abort), .chanFireComplete(chanFireComplete),
      .chanWarning(chanWarning), .chanRst(chanRst), .onYourMark(onYourMark),
      .gogogo(gogogo), .chargeTime(chargeTime), .phaseDelay(phaseDelay), .mask(mask),
      .busy(busy), .done(done), .fault(fault), .faultCode(faultCode), .shotCount(shotCount)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Channel model: cleared by reset or mark, armed by go, completes after pd+ct cycles.
   always @(negedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (chanRst || (onYourMark && !gogogo)) begin
            ch_comp[i]  = 1'b0;
            ch_armed[i] = 1'b0;
         end else if (gogogo) begin
            ch_armed[i] = 1'b1;
            ch_cnt[i]   = pd_m[i] + ct_m;
         end else if (ch_armed[i]) begin
            if (ch_cnt[i] == 0) begin
               ch_comp[i]  = 1'b1;
               ch_armed[i] = 1'b0;
            end else begin
               ch_cnt[i] = ch_cnt[i] - 1;
            end
         end
      end
      chanFireComplete = ch_comp & ~hold_low;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [4:0] a, input logic [15:0] d);
      cfgWe = 1'b1; cfgAddr = a; cfgData = d;
      tick();
      cfgWe = 1'b0;
   endtask

   task automatic fire();
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
   endtask

   initial begin
      int n;
      int n_go;
      int n_done;
      int c_comp;
      int c_rst;

      rst = 1'b1; cfgWe = 1'b0; cfgAddr = '0; cfgData = '0;
      trigger = 1'b0; abort = 1'b0; chanWarning = '0;
      tick(); tick();
      check("rst_chanrst", chanRst, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_mark_go", {onYourMark, gogogo, done, fault}, 4'b0000);
      check("rst_shot", shotCount, 16'd0);
      rst = 1'b0;
      tick();
      check("post_rst_chanrst", chanRst, 1'b0);

      // Configuration
      cfg_write(5'h00, 16'd0);
      cfg_write(5'h01, 16'd3);
      cfg_write(5'h02, 16'd5);
      cfg_write(5'h03, 16'd7);
      cfg_write(5'h05, 16'h1234);
      cfg_write(5'h10, 16'hFE0A);
      cfg_write(5'h11, 16'hFFF5);
      cfg_write(5'h12, 16'd1);
      check("phase_delay", phaseDelay, 64'h0007_0005_0003_0000);
      check("charge_time", chargeTime, 9'd10);
      check("mask", mask, 4'b0101);

      // Single shot
      fire();
      check("s1_crst", {chanRst, onYourMark, gogogo, busy}, 4'b1001);
      tick();
      check("s1_mark_a", {chanRst, onYourMark, gogogo}, 3'b010);
      tick();
      check("s1_mark_b", {chanRst, onYourMark, gogogo}, 3'b010);
      tick();
      check("s1_fire", {chanRst, onYourMark, gogogo}, 3'b011);
      n = 0;
      while (!done && n < 200) begin tick(); n++; end
      check("s1_done_latency", n, 19);
      check("s1_shot", shotCount, 16'd1);
      check("s1_busy", busy, 1'b0);
      tick();
      check("s1_done_pulse", done, 1'b0);

      // Three shots with interval 20
      cfg_write(5'h12, 16'd3);
      cfg_write(5'h13, 16'd20);
      fire();
      n_go = 0; n_done = 0; c_comp = -1; c_rst = -1; n = 0;
      while (n < 400) begin
         if (gogogo) n_go++;
         if (done) n_done++;
         if (c_comp < 0 && n_go == 1 && (&chanFireComplete)) c_comp = cyc;
         if (c_comp >= 0 && c_rst < 0 && chanRst) c_rst = cyc;
         if (done) break;
         tick(); n++;
      end
      repeat (5) begin
         tick();
         if (gogogo) n_go++;
         if (done) n_done++;
      end
      check("s3_go_count", n_go, 3);
      check("s3_done_count", n_done, 1);
      check("s3_gap_len", c_rst - c_comp, 21);
      check("s3_shot", shotCount, 16'd3);
      check("s3_idle", busy, 1'b0);

      // pulseCount zero: trigger ignored
      cfg_write(5'h12, 16'd0);
      fire();
      check("pc0_busy", {busy, chanRst}, 2'b00);
      tick();
      check("pc0_busy_b", busy, 1'b0);

      // Warning on channel 2 during WAIT
      cfg_write(5'h12, 16'd1);
      fire();
      repeat (5) tick();
      chanWarning = 4'b0100;
      tick();
      chanWarning = '0;
      check("warn_fault", {chanRst, fault, faultCode, done}, 5'b11010);
      tick();
      check("warn_after", {busy, chanRst, fault, done}, 4'b0010);

      // Timeout with channel 1 stuck
      cfg_write(5'h14, 16'd50);
      hold_low = 4'b0010;
      fire();
      check("to_fault_cleared", {fault, faultCode}, 3'b000);
      repeat (53) tick();
      check("to_before", {chanRst, fault, busy}, 3'b001);
      tick();
      check("to_fault", {chanRst, fault, faultCode}, 4'b1110);
      tick();
      check("to_idle", {busy, done}, 2'b00);
      hold_low = '0;
      cfg_write(5'h14, 16'd0);

      // Abort and warning in the same GAP cycle
      cfg_write(5'h12, 16'd2);
      fire();
      n = 0;
      while (!(&chanFireComplete) && n < 200) begin tick(); n++; end
      check("ab_reached_gap", n < 200, 1'b1);
      check("ab_shot", shotCount, 16'd1);
      abort = 1'b1; chanWarning = 4'b0001;
      tick();
      abort = 1'b0; chanWarning = '0;
      check("ab_fault", {chanRst, fault, faultCode}, 4'b1111);
      tick();
      check("ab_no_done", {done, busy}, 2'b00);

      // Config writes during busy are dropped
      cfg_write(5'h12, 16'd1);
      fire();
      tick();
      cfgWe = 1'b1; cfgAddr = 5'h10; cfgData = 16'd99;
      tick();
      cfgAddr = 5'h11; cfgData = 16'h000F;
      tick();
      cfgWe = 1'b0;
      check("busy_cfg_ct", chargeTime, 9'd10);
      check("busy_cfg_mask", mask, 4'b0101);

      // Synchronous reset in the middle of WAIT
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_ctl", {chanRst, onYourMark, gogogo, busy, done, fault}, 6'b100000);
      check("mrst_cfg", {mask, chargeTime, faultCode, shotCount}, 31'd0);
      check("mrst_pd", phaseDelay, 64'd0);
      n_done = 0;
      repeat (30) begin tick(); if (done || busy) n_done++; end
      check("mrst_quiet", n_done, 0);
      check("mrst_chanrst_low", chanRst, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
